servo_pwm_multi: RTL and testbench

Parametrised N-channel hobby-servo PWM generator; successor to the single-channel fixed-table servo driver.
- Takes position commands over a valid/ready port and converts them to pulse widths.
- All channels share one 50 Hz frame.
- Width updates occur only at frame boundaries, so pulses never glitch.
- Optional per-frame slew limiting.
- Sits between control logic (clap counter, sequencers) and the servo output pins.

---
 rtl/servo_pkg.sv | 24 ++
 rtl/servo_pwm_multi_if.sv | 16 +
 rtl/servo_slew.sv | 65 ++++++
 rtl/servo_pwm_multi.sv | 92 +++++++++
 tb/tb_servo_pwm_multi.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/servo_pkg.sv
// Shared constants and helpers for the multi-channel servo PWM generator.
// Timing defaults assume a 50 MHz clock; the width map clamps to the ceiling.
package servo_pkg;

  localparam int unsigned PERIOD_CYC_50M = 32'd1_000_000;
  localparam int unsigned MIN_CYC_50M    = 32'd25_000;
  localparam int unsigned MAX_CYC_50M    = 32'd125_000;
  localparam int unsigned SCALE_CYC_50M  = 32'd392;

  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

  // 32-bit intermediate so pos*scale cannot wrap before the clamp
  function automatic logic [31:0] pos_to_cyc(input logic [31:0] pos,
                                             input logic [31:0] min_cyc,
                                             input logic [31:0] scale_cyc,
                                             input logic [31:0] max_cyc);
    logic [31:0] w;
    w = min_cyc + (pos * scale_cyc);
    return (w > max_cyc) ? max_cyc : w;
  endfunction

endpackage

// File: rtl/servo_pwm_multi_if.sv
// Command port of servo_pwm_multi: valid/ready position command plus error pulse.
interface servo_pwm_multi_if #(
  parameter int unsigned CH_W  = 2,
  parameter int unsigned POS_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CH_W-1:0]  cmd_ch;
  logic [POS_W-1:0] cmd_pos;
  logic             cmd_err;

  modport master (output cmd_valid, output cmd_ch, output cmd_pos,
                  input  cmd_ready, input  cmd_err);
  modport slave  (input  cmd_valid, input  cmd_ch, input  cmd_pos,
                  output cmd_ready, output cmd_err);
endinterface

// File: rtl/servo_slew.sv
// Per-channel target/current pulse-width store with frame-boundary update.
// With SERVO_SLEW_EN defined the current width moves at most STEP_CYC per frame.
module servo_slew #(
  parameter int unsigned W        = 20,
  parameter logic [W-1:0] RST_CYC = '0,
  parameter int unsigned STEP_CYC = 32'd2_000
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         i_wr,
  input  logic [W-1:0] i_width,
  input  logic         i_load,
  output logic [W-1:0] o_cur,
  output logic         o_at_target
);
  logic [W-1:0] r_target;
  logic [W-1:0] r_cur;
  logic [W-1:0] w_next;

`ifdef SERVO_SLEW_EN
  logic [31:0] w_diff;

  // step toward the target without overshooting it
  always_comb begin
    w_diff = 32'd0;
    w_next = r_cur;
    if (r_target >= r_cur) begin
      w_diff = 32'(r_target) - 32'(r_cur);
      if (w_diff <= STEP_CYC) begin
        w_next = r_target;
      end else begin
        w_next = r_cur + W'(STEP_CYC);
      end
    end else begin
      w_diff = 32'(r_cur) - 32'(r_target);
      if (w_diff <= STEP_CYC) begin
        w_next = r_target;
      end else begin
        w_next = r_cur - W'(STEP_CYC);
      end
    end
  end
`else
  assign w_next = r_target;
`endif

  // target follows commands at any time; current width only moves at frame wrap
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_target <= RST_CYC;
      r_cur    <= RST_CYC;
    end else begin
      if (i_wr) begin
        r_target <= i_width;
      end
      if (i_load) begin
        r_cur <= w_next;
      end
    end
  end

  assign o_cur       = r_cur;
  assign o_at_target = (r_cur == r_target);

endmodule

// File: rtl/servo_pwm_multi.sv
// N-channel servo PWM generator sharing one frame; widths change only at frame wrap.
// Optional slew limiting is built when SERVO_SLEW_EN is defined (see servo_slew).
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int unsigned N_CH       = 32'd4,
  parameter int unsigned POS_W      = 32'd8,
  parameter int unsigned PERIOD_CYC = PERIOD_CYC_50M,
  parameter int unsigned MIN_CYC    = MIN_CYC_50M,
  parameter int unsigned MAX_CYC    = MAX_CYC_50M,
  parameter int unsigned SCALE_CYC  = SCALE_CYC_50M,
  parameter int unsigned RST_POS    = 32'd128,
  parameter int unsigned STEP_CYC   = 32'd2_000
) (
  input  logic               CLK,
  input  logic               RST_N,
  servo_pwm_multi_if.slave   cmd,
  input  logic [N_CH-1:0]    enable,
  output logic [N_CH-1:0]    PWM,
  output logic               frame_start,
  output logic [N_CH-1:0]    at_target
);
  localparam int unsigned    CNT_W   = $clog2(PERIOD_CYC);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD_CYC - 32'd1);
  localparam logic [CNT_W-1:0] RST_CYC = CNT_W'(pos_to_cyc(RST_POS, MIN_CYC, SCALE_CYC, MAX_CYC));

  logic [CNT_W-1:0] r_cnt;
  logic [N_CH-1:0]  r_en_lat;
  logic [N_CH-1:0]  r_pwm;
  logic             r_frame_start;
  logic             r_cmd_err;
  logic             w_wrap;
  logic             w_accept;
  logic             w_ch_ok;
  logic [CNT_W-1:0] w_width;
  logic [CNT_W-1:0] w_cur [N_CH];

  assign w_wrap        = (r_cnt == LAST);
  assign cmd.cmd_ready = !w_wrap;
  assign w_accept      = cmd.cmd_valid & !w_wrap;
  assign w_ch_ok       = (32'(cmd.cmd_ch) < N_CH);
  assign w_width       = CNT_W'(pos_to_cyc(32'(cmd.cmd_pos), MIN_CYC, SCALE_CYC, MAX_CYC));

  // shared frame counter, frame_start, error pulse and enable latch
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt         <= '0;
      r_frame_start <= 1'b0;
      r_cmd_err     <= 1'b0;
      r_en_lat      <= '0;
    end else begin
      r_cnt         <= w_wrap ? '0 : (r_cnt + CNT_W'(1));
      r_frame_start <= (r_cnt == '0);
      r_cmd_err     <= w_accept & !w_ch_ok;
      if (w_wrap) begin
        r_en_lat <= enable;
      end
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    servo_slew #(
      .W        (CNT_W),
      .RST_CYC  (RST_CYC),
      .STEP_CYC (STEP_CYC)
    ) u_slew (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .i_wr        (w_accept && w_ch_ok && (32'(cmd.cmd_ch) == 32'(gi))),
      .i_width     (w_width),
      .i_load      (w_wrap),
      .o_cur       (w_cur[gi]),
      .o_at_target (at_target[gi])
    );
  end

  // pulse compare; en_lat and cur are frame-stable so a pulse is never cut short
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pwm <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        r_pwm[i] <= r_en_lat[i] & (r_cnt < w_cur[i]);
      end
    end
  end

  assign PWM         = r_pwm;
  assign frame_start = r_frame_start;
  assign cmd.cmd_err = r_cmd_err;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Randomized bench for servo_pwm_multi against a frame-level reference model.
// Shortened frame timing keeps the run small; SERVO_SLEW_EN selects the slewing model.
module tb_servo_pwm_multi;
  localparam int unsigned N_CH    = 3;
  localparam int unsigned POS_W   = 8;
  localparam int unsigned PERIOD  = 1000;
  localparam int unsigned MIN_C   = 100;
  localparam int unsigned MAX_C   = 800;
  localparam int unsigned SCALE   = 3;
  localparam int unsigned RST_POS = 128;
  localparam int unsigned STEP    = 50;
  localparam int unsigned CH_W    = servo_pkg::ch_w(N_CH);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N_CH-1:0] enable;
  logic [N_CH-1:0] pwm;
  logic [N_CH-1:0] at_target;
  logic            frame_start;

  servo_pwm_multi_if #(.CH_W(CH_W), .POS_W(POS_W)) cmd_if ();

  servo_pwm_multi #(
    .N_CH(N_CH), .POS_W(POS_W), .PERIOD_CYC(PERIOD), .MIN_CYC(MIN_C),
    .MAX_CYC(MAX_C), .SCALE_CYC(SCALE), .RST_POS(RST_POS), .STEP_CYC(STEP)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .cmd(cmd_if), .enable(enable),
    .PWM(pwm), .frame_start(frame_start), .at_target(at_target)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model state: count within frame, frame index, per-channel widths
  int m_cnt, m_frame;
  int tgt [N_CH];
  int cur [N_CH];
  bit en  [N_CH];
  int exp_cur [N_CH];
  int exp_prev [N_CH];
  bit m_fs, m_err;
  int hi [N_CH];
  int rise [N_CH];
  int edges [N_CH];
  bit prev [N_CH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (frame %0d cnt %0d)", tag, got, exp, m_frame, m_cnt);
    end
  endtask

  function automatic int pos_width(input int p);
    int w;
    w = MIN_C + p * SCALE;
    return (w > MAX_C) ? MAX_C : w;
  endfunction

  function automatic int next_w(input int c, input int t);
`ifdef SERVO_SLEW_EN
    if (((t > c) ? t - c : c - t) <= STEP) return t;
    return (t > c) ? c + STEP : c - STEP;
`else
    return t + 0 * c;
`endif
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_fs = 0; m_err = 0;
    for (int i = 0; i < N_CH; i++) begin
      tgt[i] = pos_width(RST_POS); cur[i] = tgt[i]; en[i] = 0;
      exp_cur[i] = 0; exp_prev[i] = 0;
      hi[i] = 0; rise[i] = -1; edges[i] = 0; prev[i] = 0;
    end
  endtask

  // compare all observable outputs for the current cycle; pulse widths at frame wrap
  task automatic check_all();
    logic [N_CH-1:0] exp_at;
    check_eq("cmd_ready", 32'(cmd_if.cmd_ready), 32'(m_cnt != PERIOD - 1));
    check_eq("frame_start", 32'(frame_start), 32'(m_fs));
    check_eq("cmd_err", 32'(cmd_if.cmd_err), 32'(m_err));
    for (int i = 0; i < N_CH; i++) exp_at[i] = (cur[i] == tgt[i]);
    check_eq("at_target", 32'(at_target), 32'(exp_at));
    for (int i = 0; i < N_CH; i++) begin
      if (pwm[i]) begin
        hi[i]++;
        if (rise[i] < 0) rise[i] = m_cnt;
        if (!prev[i]) edges[i]++;
      end
      prev[i] = pwm[i];
    end
    if (m_cnt == 0) begin
      for (int i = 0; i < N_CH; i++) begin
        check_eq($sformatf("width_ch%0d", i), 32'(hi[i]), 32'(exp_prev[i]));
        if (exp_prev[i] > 0) begin
          check_eq($sformatf("rise_ch%0d", i), 32'(rise[i]), 32'd1);
          check_eq($sformatf("edges_ch%0d", i), 32'(edges[i]), 32'd1);
        end
        hi[i] = 0; rise[i] = -1; edges[i] = 0;
      end
    end
  endtask

  // effect of the coming rising edge on the model
  task automatic model_edge(input bit v, input int ch, input int pos, input logic [N_CH-1:0] enab);
    bit acc;
    acc = v && (m_cnt != PERIOD - 1);
    m_err = acc && (ch >= N_CH);
    if (acc && ch < N_CH) tgt[ch] = pos_width(pos);
    m_fs = (m_cnt == 0);
    if (m_cnt == PERIOD - 1) begin
      for (int i = 0; i < N_CH; i++) begin
        en[i] = enab[i];
        cur[i] = next_w(cur[i], tgt[i]);
        exp_prev[i] = exp_cur[i];
        exp_cur[i] = en[i] ? cur[i] : 0;
      end
      m_cnt = 0;
      m_frame++;
    end else begin
      m_cnt++;
    end
  endtask

  initial begin
    bit v;
    int ch, pos, cyc;
    bit did_rst;
    logic [N_CH-1:0] exp_hi;
    did_rst = 0;
    m_frame = 0;
    enable = '0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_ch = '0;
    cmd_if.cmd_pos = '0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;
    enable = '1;
    model_edge(1'b0, 0, 0, enable);
    cyc = 0;
    while (!(m_frame == 25 && m_cnt == 2) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      check_all();
      if (m_frame == 22 && m_cnt == 50 && !did_rst) begin
        did_rst = 1;
        for (int i = 0; i < N_CH; i++) exp_hi[i] = (exp_cur[i] > 49);
        check_eq("pwm_before_rst", 32'(pwm), 32'(exp_hi));
        #2 rst_n = 1'b0;
        #1;
        check_eq("pwm_async_rst", 32'(pwm), 32'd0);
        check_eq("at_target_rst", 32'(at_target), 32'((1 << N_CH) - 1));
        model_reset();
        cmd_if.cmd_valid = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_all();
        end
        rst_n = 1'b1;
      end
      v = 0; ch = 0; pos = 0;
      if (m_frame == 2 && m_cnt >= 300 && m_cnt <= 303) begin
        v = 1; ch = m_cnt - 300;
        pos = (ch == 0) ? 255 : (ch == 1) ? 0 : (ch == 2) ? 200 : 10;
      end else if ((m_frame == 4 && m_cnt >= PERIOD - 3) || (m_frame == 5 && m_cnt == 0)) begin
        v = 1; ch = 1; pos = int'($urandom_range(0, 255));
      end else if (m_frame >= 9 && m_frame <= 20 && $urandom_range(0, 39) == 0) begin
        v = 1; ch = int'($urandom_range(0, 3)); pos = int'($urandom_range(0, 255));
      end
      if (m_frame == 6 && m_cnt == 100) enable = 3'b011;
      if (m_frame == 8 && m_cnt == 500) enable = 3'b111;
      if (m_frame >= 9 && m_frame <= 20 && m_cnt == 500 && $urandom_range(0, 2) == 0)
        enable = 3'($urandom_range(0, 7));
      if (m_frame == 21 && m_cnt == 10) enable = 3'b111;
      cmd_if.cmd_valid = v;
      cmd_if.cmd_ch = CH_W'(ch);
      cmd_if.cmd_pos = POS_W'(pos);
      model_edge(v, ch, pos, enable);
    end
    check_eq("run_completed", 32'(m_frame), 32'd25);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
